// File: rtl/shift_register_4bit_right.sv
// 4-bit right-shift register: serial input at the MSB, synchronous parallel preset,
// asynchronous active-high clear, and complementary registered outputs.

module shift_register_4bit_right_cell (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_d,
  output logic o_q,
  output logic o_qn
);

  logic r_q;
  logic r_qn;

  // The complement has its own flop, so q and qn change at the same instant
  // and stay complementary through clear.
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_q  <= 1'b0;
      r_qn <= 1'b1;
    end else begin
      r_q  <= i_d;
      r_qn <= ~i_d;
    end
  end

  assign o_q  = r_q;
  assign o_qn = r_qn;

endmodule

module shift_register_4bit_right #(
  parameter int WIDTH = 4
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             serialInput,
  input  logic             enablePreset,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] notout
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qn;
  logic [WIDTH-1:0] w_next;

  // Preset has priority over shifting. Bit 0 falls off the end; this is not a rotate.
  always_comb begin
    w_next = {serialInput, w_q[WIDTH-1:1]};
    if (enablePreset)
      w_next = preset;
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    shift_register_4bit_right_cell u_cell (
      .i_clk (clockpulse),
      .i_clr (clear),
      .i_d   (w_next[g]),
      .o_q   (w_q[g]),
      .o_qn  (w_qn[g])
    );
  end

  assign out    = w_q;
  assign notout = w_qn;

endmodule

// File: tb/tb_shift_register_4bit_right.sv
// Directed bench for shift_register_4bit_right; expected values are worked out by hand
// for each vector below.

module tb_shift_register_4bit_right;

  logic       clockpulse;
  logic       clear;
  logic       serialInput;
  logic       enablePreset;
  logic [3:0] preset;
  logic [3:0] out;
  logic [3:0] notout;

  int n_checks = 0;
  int n_pass   = 0;

  shift_register_4bit_right #(.WIDTH(4)) dut (
    .clockpulse   (clockpulse),
    .clear        (clear),
    .serialInput  (serialInput),
    .enablePreset (enablePreset),
    .preset       (preset),
    .out          (out),
    .notout       (notout)
  );

  initial clockpulse = 1'b0;
  always #5 clockpulse = ~clockpulse;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs === exp)
      n_pass++;
    else
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
  endtask

  // Checks both outputs against one hand-computed value; notout must be its complement.
  task automatic check_out(input string tag, input logic [3:0] exp);
    check({tag, ".out"}, out, exp);
    check({tag, ".notout"}, notout, ~exp);
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clockpulse);
    #1;
  endtask

  initial begin
    clear        = 1'b1;
    serialInput  = 1'b0;
    enablePreset = 1'b0;
    preset       = 4'b0000;

    // Reset held across several clock edges.
    #1;
    check_out("rst_t1", 4'b0000);
    enablePreset = 1'b1;
    preset       = 4'b1111;
    serialInput  = 1'b1;
    tick();
    check_out("rst_e1", 4'b0000);
    tick();
    check_out("rst_e2", 4'b0000);

    // Release clear between edges: nothing changes until the next rising edge.
    #4;
    clear        = 1'b0;
    enablePreset = 1'b1;
    preset       = 4'b0011;
    serialInput  = 1'b0;
    #1;
    check_out("rel", 4'b0000);

    // Preset then shift out over a 15-edge run.
    tick();
    check_out("pre_e1", 4'b0011);
    enablePreset = 1'b0;
    tick();
    check_out("shr_e2", 4'b0001);
    // Toggle serialInput away from the edge; only the value at the edge counts.
    #2 serialInput = 1'b1;
    #2 serialInput = 1'b0;
    tick();
    check_out("shr_e3", 4'b0000);
    for (int i = 4; i <= 15; i++) begin
      tick();
      check_out($sformatf("hold_e%0d", i), 4'b0000);
    end

    // Serial fill then drain.
    serialInput = 1'b1;
    tick(); check_out("fill1", 4'b1000);
    tick(); check_out("fill2", 4'b1100);
    tick(); check_out("fill3", 4'b1110);
    tick(); check_out("fill4", 4'b1111);
    serialInput = 1'b0;
    tick(); check_out("drain1", 4'b0111);
    tick(); check_out("drain2", 4'b0011);

    // Preset wins over shifting.
    enablePreset = 1'b1;
    preset       = 4'b1010;
    tick(); check_out("ld_1010", 4'b1010);
    preset      = 4'b0101;
    serialInput = 1'b1;
    tick(); check_out("prio", 4'b0101);

    // Asynchronous clear between edges.
    preset      = 4'b0011;
    serialInput = 1'b0;
    tick(); check_out("ld_0011", 4'b0011);
    enablePreset = 1'b0;
    #4;
    clear = 1'b1;
    #1;
    check_out("aclr", 4'b0000);
    enablePreset = 1'b1;
    preset       = 4'b1111;
    tick(); check_out("clr_pre", 4'b0000);
    #4;
    clear        = 1'b0;
    enablePreset = 1'b0;
    serialInput  = 1'b1;
    #1;
    check_out("rel2", 4'b0000);
    tick(); check_out("recover", 4'b1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_register_4bit_right.md
Name: shift_register_4bit_right

Overview:
- 4-bit right-shift register with synchronous parallel preset, serial input at the MSB, and complementary outputs.
- Used as the register datapath element for serial/parallel data movement in the lab design.
- Every bit is held in a dedicated flip-flop cell.
- Bit 3 takes the serial input; bit 0 shifts out and is discarded.

Parameters:
- WIDTH, 4, register width in bits. All behaviour below is defined for WIDTH=4; other values scale identically.

Ports:
- clockpulse  input  1  single clock; all state changes except clear occur on the rising edge.
- clear  input  1  asynchronous, active-high reset; forces all bits to 0.
- serialInput  input  1  serial data shifted into out[3] on each shift cycle.
- enablePreset  input  1  synchronous parallel-load enable, active-high.
- preset  input  4  parallel load value.
- out  output  4  register contents; out[3] is MSB.
- notout  output  4  bitwise complement of out.

Behaviour:
- Reset:
  - While clear=1, out=4'b0000 and notout=4'b1111 immediately, independent of clockpulse.
  - Clear overrides enablePreset and shifting.
  - Clocks are ignored while clear is held.
  - Clear asserted between edges takes effect without waiting for an edge.
- Release of clear: no state change until the next rising edge of clockpulse.
- Rising edge of clockpulse with clear=0, in priority order:
  - enablePreset=1: out <= preset (parallel load; serialInput ignored).
  - enablePreset=0: right shift:
    - out[3] <= serialInput
    - out[2] <= out[3]
    - out[1] <= out[2]
    - out[0] <= out[1]
    - the old out[0] is lost.
- Latency:
  - Load and shift results are visible one edge later (registered outputs, no combinational path from preset or serialInput to out).
  - notout is the registered complement of out, updated at the same instant: notout == ~out at all times, including during reset.
- Falling edge of clockpulse: no effect.
- enablePreset, preset and serialInput are sampled only at the rising edge. Changes at other times have no effect.
- Wrap-around: none; this is not a rotate.
  - With serialInput=0, any value reaches 0000 after at most 4 shifts and stays there.
  - With serialInput=1, it fills to 1111 after 4 shifts.
- No undefined states after the first clear. Power-up contents before any clear are unspecified; the bench must apply clear first.

Test Plan:
- Reset: clear=1 for 10 time units with clockpulse toggling or idle -> out=0000, notout=1111 throughout.
- Preset then shift out: clear=0, preset=0011, serialInput=0, enablePreset=1 for the first rising edge only -> out=0011 (notout=1100). Subsequent edges give 0001, then 0000. It stays 0000 for the remaining edges of a 15-edge run.
- Serial fill: from 0000, enablePreset=0, serialInput=1 for 4 edges -> 1000, 1100, 1110, 1111. Then serialInput=0 for 2 edges -> 0111, 0011.
- Preset priority: out=1010, enablePreset=1, preset=0101, serialInput=1, one edge -> out=0101 (no shift).
- Async clear mid-operation: out=0011; assert clear midway between edges -> out=0000 and notout=1111 immediately, before the next edge. Clear=1 together with enablePreset=1 at an edge -> out stays 0000.
- Complement invariant: across all scenarios, check notout == ~out at every sample point.
